// File: rtl/rr_mux_reg.sv
// Registered N-channel valid/ready multiplexer with round-robin or fixed-priority
// arbitration and a one-entry output register (one-cycle latency, full throughput).
module rr_mux_reg #(
   parameter  int unsigned WIDTH    = 32,
   parameter  int unsigned CHANNELS = 4,
   localparam int unsigned SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mode,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_sel,
   input  logic                      out_ready
);

   localparam logic [SELW-1:0] LAST_IDX = SELW'(CHANNELS - 1);

   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q,  out_data_d;
   logic [SELW-1:0]     out_sel_q,   out_sel_d;
   logic [SELW-1:0]     ptr_q,       ptr_d;

   logic                can_accept;
   logic                grant_found;
   logic [SELW-1:0]     grant_idx;
   logic [SELW-1:0]     start_idx;
   logic [WIDTH-1:0]    grant_data;
   logic                xfer;

   // Two-pass priority scan: indices >= start first, then wrap to indices below start.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      start_idx   = mode ? '0 : ptr_q;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (!grant_found && in_valid[i] && (SELW'(i) >= start_idx)) begin
            grant_found = 1'b1;
            grant_idx   = SELW'(i);
         end
      end
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (!grant_found && in_valid[i] && (SELW'(i) < start_idx)) begin
            grant_found = 1'b1;
            grant_idx   = SELW'(i);
         end
      end
   end

   // Grant data select and one-hot ready; reset suppresses any accept.
   always_comb begin
      can_accept = !out_valid_q || out_ready;
      grant_data = '0;
      in_ready   = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (grant_idx == SELW'(i)) begin
            grant_data  = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = !reset && can_accept && grant_found;
         end
      end
      xfer = |in_ready;
   end

   // Next-state for the output register and the round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data;
         out_sel_d   = grant_idx;
         if (!mode) begin
            ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + SELW'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: a 4-channel instance for the main scenarios and
// a 3-channel instance for pointer wrap at a non-power-of-two channel count.
module tb_rr_mux_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-channel instance
   logic         reset4, mode4, out_ready4;
   logic [3:0]   in_valid4, in_ready4;
   logic [127:0] in_data4;
   logic         out_valid4;
   logic [31:0]  out_data4;
   logic [1:0]   out_sel4;

   // 3-channel instance
   logic         reset3, mode3, out_ready3;
   logic [2:0]   in_valid3, in_ready3;
   logic [95:0]  in_data3;
   logic         out_valid3;
   logic [31:0]  out_data3;
   logic [1:0]   out_sel3;

   rr_mux_reg #(.WIDTH(32), .CHANNELS(4)) dut4 (
      .clk(clk), .reset(reset4), .mode(mode4),
      .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
      .out_valid(out_valid4), .out_data(out_data4), .out_sel(out_sel4),
      .out_ready(out_ready4)
   );

   rr_mux_reg #(.WIDTH(32), .CHANNELS(3)) dut3 (
      .clk(clk), .reset(reset3), .mode(mode3),
      .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
      .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
      .out_ready(out_ready3)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out4(input string tag, input logic v, input logic [31:0] d, input logic [1:0] s);
      chk({tag, ".valid"}, 64'(out_valid4), 64'(v));
      chk({tag, ".data"},  64'(out_data4),  64'(d));
      chk({tag, ".sel"},   64'(out_sel4),   64'(s));
   endtask

   initial begin
      logic [1:0] rr_sel [6];
      rr_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      reset4 = 1'b1; mode4 = 1'b0; out_ready4 = 1'b0; in_valid4 = '0; in_data4 = '0;
      reset3 = 1'b1; mode3 = 1'b0; out_ready3 = 1'b0; in_valid3 = '0; in_data3 = '0;
      edge_wait();
      edge_wait();

      // Reset/idle state
      chk_out4("reset_idle", 1'b0, 32'h0, 2'd0);
      chk("reset_idle.in_ready", 64'(in_ready4), 64'h0);

      // Round-robin fairness with all channels valid
      reset4 = 1'b0;
      for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'hA0 + 32'(i);
      in_valid4 = 4'b1111; out_ready4 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("rr%0d.in_ready", k), 64'(in_ready4), 64'(4'b0001 << rr_sel[k]));
         edge_wait();
         chk_out4($sformatf("rr%0d", k), 1'b1, 32'hA0 + 32'(rr_sel[k]), rr_sel[k]);
      end

      // Drain without refill: valid drops, data/sel hold
      in_valid4 = '0;
      #1;
      chk("drain.in_ready", 64'(in_ready4), 64'h0);
      edge_wait();
      chk_out4("drain", 1'b0, 32'hA1, 2'd1);

      // Fixed priority: channels 1 and 3 valid, channel 1 always wins
      mode4 = 1'b1; in_valid4 = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("fix%0d.in_ready", k), 64'(in_ready4), 64'(4'b0010));
         edge_wait();
         chk_out4($sformatf("fix%0d", k), 1'b1, 32'hA1, 2'd1);
      end

      // Back to round-robin: held ptr=2 grants channel 3 first, then channel 1
      mode4 = 1'b0;
      #1;
      chk("rr_resume0.in_ready", 64'(in_ready4), 64'(4'b1000));
      edge_wait();
      chk_out4("rr_resume0", 1'b1, 32'hA3, 2'd3);
      #1;
      chk("rr_resume1.in_ready", 64'(in_ready4), 64'(4'b0010));
      edge_wait();
      chk_out4("rr_resume1", 1'b1, 32'hA1, 2'd1);

      // Backpressure: load DEADBEEF on channel 2, then stall 5 cycles
      in_data4[2*32 +: 32] = 32'hDEAD_BEEF;
      in_valid4 = 4'b0100;
      #1;
      chk("bp_load.in_ready", 64'(in_ready4), 64'(4'b0100));
      edge_wait();
      chk_out4("bp_load", 1'b1, 32'hDEAD_BEEF, 2'd2);
      out_ready4 = 1'b0; in_valid4 = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp_stall%0d.in_ready", k), 64'(in_ready4), 64'h0);
         edge_wait();
         chk_out4($sformatf("bp_stall%0d", k), 1'b1, 32'hDEAD_BEEF, 2'd2);
      end
      out_ready4 = 1'b1;
      #1;
      chk("bp_release.in_ready", 64'(in_ready4), 64'(4'b1000));
      edge_wait();
      chk_out4("bp_release", 1'b1, 32'hA3, 2'd3);

      // Set ptr to 2 with a channel-1 transfer, then stall a pending word
      in_valid4 = 4'b0010;
      edge_wait();
      chk_out4("pre_reset", 1'b1, 32'hA1, 2'd1);
      out_ready4 = 1'b0; in_valid4 = 4'b1111;
      edge_wait();
      chk_out4("pre_reset_stall", 1'b1, 32'hA1, 2'd1);

      // Reset mid-stall: ready forced low even though the consumer is ready
      reset4 = 1'b1; out_ready4 = 1'b1;
      #1;
      chk("reset_cycle.in_ready", 64'(in_ready4), 64'h0);
      edge_wait();
      chk_out4("reset_mid", 1'b0, 32'h0, 2'd0);
      reset4 = 1'b0; in_valid4 = 4'b1010;
      #1;
      chk("post_reset.in_ready", 64'(in_ready4), 64'(4'b0010));
      edge_wait();
      chk_out4("post_reset", 1'b1, 32'hA1, 2'd1);
      in_valid4 = '0;

      // 3-channel pointer wrap: channel 2 then channel 0 granted immediately
      reset3 = 1'b0; out_ready3 = 1'b1;
      in_data3 = {32'hC2, 32'hC1, 32'hC0};
      in_valid3 = 3'b100;
      #1;
      chk("wrap_ch2.in_ready", 64'(in_ready3), 64'(3'b100));
      edge_wait();
      chk("wrap_ch2.sel",  64'(out_sel3),  64'd2);
      chk("wrap_ch2.data", 64'(out_data3), 64'hC2);
      in_valid3 = 3'b001;
      #1;
      chk("wrap_ch0.in_ready", 64'(in_ready3), 64'(3'b001));
      edge_wait();
      chk("wrap_ch0.valid", 64'(out_valid3), 64'd1);
      chk("wrap_ch0.sel",   64'(out_sel3),   64'd0);
      chk("wrap_ch0.data",  64'(out_data3),  64'hC0);
      in_valid3 = 3'b011;
      #1;
      chk("wrap_next.in_ready", 64'(in_ready3), 64'(3'b010));
      edge_wait();
      chk("wrap_next.sel", 64'(out_sel3), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Registered, parametrised N-channel multiplexer with valid/ready handshakes and round-robin or fixed-priority arbitration. It generalises the combinational 2/4-way selectors to any channel count from 2 to 8. A one-entry output register gives one-cycle latency and full throughput. It sits between multiple pipeline producers (e.g. exception/interrupt request sources, memory-side requesters) and a single downstream consumer.

## Interface
- `WIDTH`, 32, data width per channel (1..64)
- `CHANNELS`, 4, number of input channels (2..8)
- `SELW`, `$clog2(CHANNELS)`, width of channel index; derived, not overridden
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mode`  in  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled every cycle
- `in_valid`  in  CHANNELS  per-channel request valid
- `in_data`  in  CHANNELS*WIDTH  flattened data; channel i at bits [i*WIDTH +: WIDTH]
- `in_ready`  out  CHANNELS  per-channel accept; one-hot or zero
- `out_valid`  out  1  output register holds a word
- `out_data`  out  WIDTH  registered data of the granted channel
- `out_sel`  out  SELW  index of the channel that supplied `out_data`
- `out_ready`  in  1  consumer accepts `out_data` this cycle

## Operation
- `can_accept = !out_valid || out_ready`.
- Grant is combinational from `in_valid`, `mode` and the priority pointer `ptr` (SELW bits):
  - round-robin: first valid channel scanning `ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1`;
  - fixed: lowest-index valid channel, `ptr` ignored.
- `in_ready[g] = can_accept && in_valid[g]` for grant g; all other bits are 0. `in_ready` is 0 when no channel is valid.
- A transfer on channel g is `in_valid[g] && in_ready[g]`. On a transfer:
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`;
  - in round-robin only, `ptr <= (g == CHANNELS-1) ? 0 : g+1`. This wraps at CHANNELS, not at 2^SELW.
- No transfer and `out_ready`: `out_valid <= 0`. `out_data` and `out_sel` hold their last value.
- No transfer and `!out_ready`: all output registers hold.
- `ptr` does not change in fixed mode. Switching `mode` takes effect in the same cycle. Returning to round-robin resumes from the held `ptr`.
- Inputs must hold `in_data` while `in_valid` is high without `in_ready`. The block does not require this for correctness, because it samples only on transfer.
- Reset (any cycle, including mid-stall): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`. A word pending in the register is discarded. `in_ready` is forced to 0 during the reset cycle.

## Timing
- Latency: transfer in cycle n → `out_valid=1` with that data in cycle n+1.
- Throughput: one word per cycle while `out_ready` stays high. Simultaneous drain and refill in the same cycle are supported.
- Backpressure: with `out_valid && !out_ready`, `in_ready` is all-zero. `out_data`/`out_sel` are stable until the cycle after `out_ready` is seen.
- Combinational paths: `in_valid`, `mode`, `out_ready` → `in_ready`. There is no combinational path from inputs to `out_*`.
- Fairness (round-robin): a continuously valid channel is granted within CHANNELS transfers.

## Test plan
- Reset/idle: assert `reset` with `out_valid=1` pending and `out_ready=0` → next cycle `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0000`.
- Round-robin fairness: CHANNELS=4, mode=0, all valid, `in_data[i]=32'hA0+i`, `out_ready=1` → `out_sel` sequence 0,1,2,3,0,1 and `out_data` 0xA0,0xA1,0xA2,0xA3,0xA0,0xA1, one per cycle.
- Fixed priority: mode=1, channels 1 and 3 valid continuously → `out_sel` is always 1 and channel 3 never receives `in_ready`. Then switch to mode=0 → channel 3 is granted within 2 transfers.
- Backpressure: one transfer on channel 2 (`32'hDEAD_BEEF`), then hold `out_ready=0` for 5 cycles → `out_valid=1`, `out_data=32'hDEAD_BEEF`, `out_sel=2` stable and `in_ready=0000` throughout. Release → next word loads the following cycle.
- Pointer wrap / sparse: CHANNELS=3 (SELW=2), only channel 2 valid for one transfer, then only channel 0 valid → `ptr` wraps to 0 (never 3) and channel 0 is granted immediately.
- Drain without refill: `out_valid=1`, `out_ready=1`, no `in_valid` → `out_valid=0` next cycle, with `out_data`/`out_sel` unchanged.
